inst_fetch_unit: RTL and testbench

- Instruction fetch stage between the program-counter logic and an instruction memory with request/response handshakes.
- Keeps its own fetch PC and issues sequential word fetches ahead of the consumer.
- Buffers returned instructions, tagged with their PC, in a small in-order prefetch FIFO feeding decode.
- Accepts branch/jump redirects from execute: flushes the FIFO and discards stale in-flight responses.

---
 rtl/inst_fetch_unit_if.sv | 27 ++
 rtl/inst_fetch_unit.sv | 98 +++++++++
 tb/tb_inst_fetch_unit.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_unit_if.sv
// Handshake bundle between the fetch unit, instruction memory, execute redirect
// and decode. The master modport is the fetch unit's view.
interface inst_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: sequential prefetch into a PC-tagged in-order FIFO,
// with redirect flush and stale in-flight response dropping.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                clk,
  input logic                rst,
  inst_fetch_unit_if.master  io_fetch
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_L = FIFO_DEPTH[CW:0];

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FLUSH} state_t;

  state_t        r_state, w_state_next;
  logic [31:0]   r_fetch_pc, r_rsp_pc;
  logic [CW-1:0] r_outstanding, r_count, w_outstanding_next;
  logic [PW-1:0] r_wptr, r_rptr;
  logic [31:0]   r_data_mem [FIFO_DEPTH];
  logic [31:0]   r_pc_mem   [FIFO_DEPTH];

  logic        w_req_valid, w_req_fire, w_rsp_acc, w_push, w_pop, w_inst_valid;
  logic [CW:0] w_inflight;
  logic [31:0] w_redirect_tgt;

  always_comb begin
    w_inflight     = {1'b0, r_outstanding} + {1'b0, r_count};
    w_req_valid    = (r_state == S_FETCH) && (w_inflight < DEPTH_L) && !io_fetch.redirect_valid;
    w_req_fire     = w_req_valid && io_fetch.imem_req_ready;
    w_rsp_acc      = io_fetch.imem_rsp_valid && (r_outstanding != '0);
    w_push         = w_rsp_acc && (r_state == S_FETCH) && !io_fetch.redirect_valid;
    w_inst_valid   = (r_count != '0);
    w_pop          = w_inst_valid && io_fetch.inst_ready;
    w_outstanding_next = r_outstanding + {{PW{1'b0}}, w_req_fire} - {{PW{1'b0}}, w_rsp_acc};
    w_redirect_tgt = {io_fetch.redirect_pc[31:2], 2'b00};
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  w_state_next = S_FETCH;
      S_FETCH: if (io_fetch.redirect_valid && (w_outstanding_next != '0)) w_state_next = S_FLUSH;
      S_FLUSH: if (w_outstanding_next == '0) w_state_next = S_FETCH;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
    end else begin
      r_state       <= w_state_next;
      r_outstanding <= w_outstanding_next;
      if (io_fetch.redirect_valid) begin
        r_fetch_pc <= w_redirect_tgt;
        r_rsp_pc   <= w_redirect_tgt;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_push)     r_rsp_pc   <= r_rsp_pc + 32'd4;
      end
    end
  end

  // Redirect wins over push/pop: the FIFO restarts empty regardless of this cycle's traffic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (io_fetch.redirect_valid) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data_mem[r_wptr] <= io_fetch.imem_rsp_data;
      r_pc_mem[r_wptr]   <= r_rsp_pc;
    end
  end

  assign io_fetch.imem_req_valid = w_req_valid;
  assign io_fetch.imem_req_addr  = r_fetch_pc;
  assign io_fetch.inst_valid     = w_inst_valid;
  assign io_fetch.inst_data      = w_inst_valid ? r_data_mem[r_rptr] : '0;
  assign io_fetch.inst_pc        = w_inst_valid ? r_pc_mem[r_rptr]   : '0;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a queued instruction-memory model
// whose returned word is the request address XOR a fixed key.
module tb_inst_fetch_unit;
  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_fetch_unit_if bus();

  inst_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .io_fetch(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];
  logic  mem_ready = 1'b1;
  int    mem_lat   = 1;
  int    fire_cnt  = 0;
  int    mcyc      = 0;

  assign bus.imem_req_ready = mem_ready;

  always @(posedge clk) mcyc <= mcyc + 1;

  // Memory acts 2 time units after each falling edge, after tests have driven inputs.
  initial begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      #2;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      if (rst) begin
        mq.delete();
      end else begin
        if (mq.size() > 0 && mq[0].due == mcyc + 1) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = mq[0].addr ^ KEY;
          void'(mq.pop_front());
        end
        if (bus.imem_req_valid && mem_ready) begin
          mq.push_back('{bus.imem_req_addr, mcyc + 1 + mem_lat});
          fire_cnt++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic reset_dut(input logic iready, input logic mready, input int lat);
    @(negedge clk);
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = iready;
    mem_ready          = mready;
    mem_lat            = lat;
    @(negedge clk);
    @(negedge clk);
    fire_cnt = 0;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid); end
    n_checks++; if (bus.imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_req_addr: got %h want 00000000", bus.imem_req_addr); end
    n_checks++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %b want 0", bus.inst_valid); end
    n_checks++; if (bus.inst_data !== 32'h0) begin n_fail++; $display("FAIL reset_inst_data: got %h want 00000000", bus.inst_data); end
    n_checks++; if (bus.inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_inst_pc: got %h want 00000000", bus.inst_pc); end
  endtask

  task automatic test_stream;
    logic [31:0] e;
    reset_dut(1'b1, 1'b1, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      e = 32'(4 * i);
      n_checks++; if (bus.imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL stream_req_valid[%0d]: got %b want 1", i, bus.imem_req_valid); end
      n_checks++; if (bus.imem_req_addr !== e) begin n_fail++; $display("FAIL stream_req_addr[%0d]: got %h want %h", i, bus.imem_req_addr, e); end
      if (i >= 2) begin
        e = 32'(4 * (i - 2));
        n_checks++; if (bus.inst_valid !== 1'b1) begin n_fail++; $display("FAIL stream_inst_valid[%0d]: got %b want 1", i, bus.inst_valid); end
        n_checks++; if (bus.inst_pc !== e) begin n_fail++; $display("FAIL stream_inst_pc[%0d]: got %h want %h", i, bus.inst_pc, e); end
        n_checks++; if (bus.inst_data !== (e ^ KEY)) begin n_fail++; $display("FAIL stream_inst_data[%0d]: got %h want %h", i, bus.inst_data, e ^ KEY); end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] e;
    reset_dut(1'b0, 1'b1, 1);
    repeat (8) @(negedge clk);
    n_checks++; if (fire_cnt !== 4) begin n_fail++; $display("FAIL bp_fire_count: got %0d want 4", fire_cnt); end
    n_checks++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_valid_full: got %b want 0", bus.imem_req_valid); end
    n_checks++; if (bus.inst_valid !== 1'b1) begin n_fail++; $display("FAIL bp_inst_valid: got %b want 1", bus.inst_valid); end
    n_checks++; if (bus.inst_pc !== 32'h0) begin n_fail++; $display("FAIL bp_head_pc: got %h want 00000000", bus.inst_pc); end
    bus.inst_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.inst_pc !== 32'h4) begin n_fail++; $display("FAIL bp_pop1_pc: got %h want 00000004", bus.inst_pc); end
    n_checks++; if (bus.imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL bp_resume_valid: got %b want 1", bus.imem_req_valid); end
    n_checks++; if (bus.imem_req_addr !== 32'h10) begin n_fail++; $display("FAIL bp_resume_addr: got %h want 00000010", bus.imem_req_addr); end
    for (int j = 2; j <= 4; j++) begin
      @(negedge clk);
      e = 32'(4 * j);
      n_checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== e) begin n_fail++; $display("FAIL bp_pop_pc[%0d]: got v=%b pc=%h want v=1 pc=%h", j, bus.inst_valid, bus.inst_pc, e); end
    end
  endtask

  task automatic test_req_stall;
    reset_dut(1'b1, 1'b0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%b addr=%h want v=1 addr=00000000", i, bus.imem_req_valid, bus.imem_req_addr); end
    end
    mem_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h4) begin n_fail++; $display("FAIL stall_next: got v=%b addr=%h want v=1 addr=00000004", bus.imem_req_valid, bus.imem_req_addr); end
    n_checks++; if (fire_cnt !== 1) begin n_fail++; $display("FAIL stall_fire_count: got %0d want 1", fire_cnt); end
  endtask

  task automatic test_redirect_flush;
    reset_dut(1'b1, 1'b1, 3);
    repeat (3) @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0100;
    #1;
    n_checks++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL flush_gate: got %b want 0", bus.imem_req_valid); end
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #1;
    n_checks++; if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL flush_state1: got req=%b inst=%b want 0 0", bus.imem_req_valid, bus.inst_valid); end
    @(negedge clk);
    n_checks++; if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL flush_state2: got req=%b inst=%b want 0 0", bus.imem_req_valid, bus.inst_valid); end
    @(negedge clk);
    n_checks++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stale_drop: got %b want 0", bus.inst_valid); end
    n_checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL flush_restart: got v=%b addr=%h want v=1 addr=00000100", bus.imem_req_valid, bus.imem_req_addr); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.inst_valid) break;
    end
    n_checks++; if (bus.inst_valid !== 1'b1) begin n_fail++; $display("FAIL flush_first_inst_timeout: got %b want 1", bus.inst_valid); end
    n_checks++; if (bus.inst_pc !== 32'h100 || bus.inst_data !== (32'h100 ^ KEY)) begin n_fail++; $display("FAIL flush_first_inst: got pc=%h data=%h want pc=00000100 data=%h", bus.inst_pc, bus.inst_data, 32'h100 ^ KEY); end
  endtask

  task automatic test_redirect_collision;
    reset_dut(1'b1, 1'b1, 1);
    repeat (3) @(negedge clk);
    n_checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin n_fail++; $display("FAIL coll_head: got v=%b pc=%h want v=1 pc=00000000", bus.inst_valid, bus.inst_pc); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0203;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #1;
    n_checks++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL coll_discard: got %b want 0", bus.inst_valid); end
    n_checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h200) begin n_fail++; $display("FAIL coll_next_req: got v=%b addr=%h want v=1 addr=00000200", bus.imem_req_valid, bus.imem_req_addr); end
    repeat (2) @(negedge clk);
    n_checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h200 || bus.inst_data !== (32'h200 ^ KEY)) begin n_fail++; $display("FAIL coll_first_inst: got v=%b pc=%h data=%h want v=1 pc=00000200 data=%h", bus.inst_valid, bus.inst_pc, bus.inst_data, 32'h200 ^ KEY); end
  endtask

  task automatic test_wrap_and_reset;
    logic [31:0] e;
    reset_dut(1'b1, 1'b1, 1);
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFF8;
    #1;
    n_checks++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_gate: got %b want 0", bus.imem_req_valid); end
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      e = 32'hFFFF_FFF8 + 32'(4 * i);
      n_checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== e) begin n_fail++; $display("FAIL wrap_req[%0d]: got v=%b addr=%h want v=1 addr=%h", i, bus.imem_req_valid, bus.imem_req_addr, e); end
      if (i >= 2) begin
        e = 32'hFFFF_FFF8 + 32'(4 * (i - 2));
        n_checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== e) begin n_fail++; $display("FAIL wrap_inst[%0d]: got v=%b pc=%h want v=1 pc=%h", i, bus.inst_valid, bus.inst_pc, e); end
      end
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.imem_req_valid !== 1'b0 || bus.imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL async_rst_req: got v=%b addr=%h want v=0 addr=00000000", bus.imem_req_valid, bus.imem_req_addr); end
    n_checks++; if (bus.inst_valid !== 1'b0 || bus.inst_data !== 32'h0 || bus.inst_pc !== 32'h0) begin n_fail++; $display("FAIL async_rst_inst: got v=%b data=%h pc=%h want 0 0 0", bus.inst_valid, bus.inst_data, bus.inst_pc); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = 32'(4 * i);
      n_checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== e) begin n_fail++; $display("FAIL restart_req[%0d]: got v=%b addr=%h want v=1 addr=%h", i, bus.imem_req_valid, bus.imem_req_addr, e); end
    end
    n_checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin n_fail++; $display("FAIL restart_inst: got v=%b pc=%h want v=1 pc=00000000", bus.inst_valid, bus.inst_pc); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_req_stall();
    test_redirect_flush();
    test_redirect_collision();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
